// File: rtl/crtc_host_port.sv
// Host-side MC6845 bus initiator: turns a valid/ready register access into an
// address-register write followed by a data access, skipping the address step on a cache hit.
module crtc_host_port #(
  parameter int SETUP = 1,
  parameter int HIGH  = 2,
  parameter int HOLD  = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_reg,
  input  logic       req_read,
  input  logic [7:0] req_data,
  input  logic       ar_flush,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       E,
  output logic       CSn,
  output logic       RS,
  output logic       RW,
  output logic [7:0] D_OUT,
  output logic       D_OE,
  input  logic [7:0] D_IN
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    A_SETUP = 3'd1,
    A_HIGH  = 3'd2,
    A_HOLD  = 3'd3,
    D_SETUP = 3'd4,
    D_HIGH  = 3'd5,
    D_HOLD  = 3'd6
  } state_t;

  localparam logic [7:0] SETUP_LAST = 8'(SETUP - 1);
  localparam logic [7:0] HIGH_LAST  = 8'(HIGH - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [4:0] reg_q, reg_d;
  logic       read_q, read_d;
  logic [7:0] data_q, data_d;
  logic       cache_valid_q, cache_valid_d;
  logic [4:0] cache_reg_q, cache_reg_d;
  logic       flush_pend_q, flush_pend_d;
  logic       rd_valid_q, rd_valid_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic       last_s;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      reg_q         <= 5'd0;
      read_q        <= 1'b0;
      data_q        <= 8'd0;
      cache_valid_q <= 1'b0;
      cache_reg_q   <= 5'd0;
      flush_pend_q  <= 1'b0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reg_q         <= reg_d;
      read_q        <= read_d;
      data_q        <= data_d;
      cache_valid_q <= cache_valid_d;
      cache_reg_q   <= cache_reg_d;
      flush_pend_q  <= flush_pend_d;
      rd_valid_q    <= rd_valid_d;
      rd_data_q     <= rd_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 8'd1;
    reg_d        = reg_q;
    read_d       = read_q;
    data_d       = data_q;
    cache_reg_d  = cache_reg_q;
    flush_pend_d = flush_pend_q;
    rd_valid_d   = 1'b0;
    rd_data_d    = rd_data_q;
    last_s       = 1'b0;
    if (ar_flush) begin
      cache_valid_d = 1'b0;
    end else begin
      cache_valid_d = cache_valid_q;
    end

    case (state_q)
      A_SETUP, D_SETUP: last_s = (cnt_q == SETUP_LAST);
      A_HIGH,  D_HIGH:  last_s = (cnt_q == HIGH_LAST);
      A_HOLD,  D_HOLD:  last_s = (cnt_q == HOLD_LAST);
      default:          last_s = 1'b0;
    endcase
    if (last_s) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (req_valid) begin
          reg_d  = req_reg;
          read_d = req_read;
          data_d = req_data;
          if (!cache_valid_q || (cache_reg_q != req_reg) || ar_flush) begin
            state_d      = A_SETUP;
            flush_pend_d = ar_flush;
          end else begin
            state_d = D_SETUP;
          end
        end else begin
          state_d = IDLE;
        end
      end
      A_SETUP: begin
        flush_pend_d = flush_pend_q | ar_flush;
        if (last_s) state_d = A_HIGH;
        else        state_d = A_SETUP;
      end
      A_HIGH: begin
        flush_pend_d = flush_pend_q | ar_flush;
        if (last_s) state_d = A_HOLD;
        else        state_d = A_HIGH;
      end
      A_HOLD: begin
        flush_pend_d = flush_pend_q | ar_flush;
        // A flush seen anywhere in the address cycle keeps the cache invalid.
        if (last_s) begin
          state_d       = D_SETUP;
          cache_valid_d = !(flush_pend_q | ar_flush);
          cache_reg_d   = reg_q;
        end else begin
          state_d = A_HOLD;
        end
      end
      D_SETUP: begin
        if (last_s) state_d = D_HIGH;
        else        state_d = D_SETUP;
      end
      D_HIGH: begin
        if (last_s) begin
          state_d = D_HOLD;
          if (read_q) rd_data_d = D_IN;
          else        rd_data_d = rd_data_q;
        end else begin
          state_d = D_HIGH;
        end
      end
      D_HOLD: begin
        if (last_s) begin
          state_d    = IDLE;
          rd_valid_d = read_q;
        end else begin
          state_d = D_HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus pins decode from registered state only.
  always_comb begin
    req_ready = 1'b0;
    E         = 1'b0;
    CSn       = 1'b0;
    RS        = 1'b0;
    RW        = 1'b0;
    D_OE      = 1'b0;
    D_OUT     = 8'd0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        CSn       = 1'b1;
        RW        = 1'b1;
      end
      A_SETUP, A_HIGH, A_HOLD: begin
        E     = (state_q == A_HIGH);
        D_OE  = 1'b1;
        D_OUT = {3'b000, reg_q};
      end
      D_SETUP, D_HIGH, D_HOLD: begin
        E    = (state_q == D_HIGH);
        RS   = 1'b1;
        RW   = read_q;
        D_OE = !read_q;
        if (read_q) D_OUT = 8'd0;
        else        D_OUT = data_q;
      end
      default: begin
        req_ready = 1'b1;
        CSn       = 1'b1;
        RW        = 1'b1;
      end
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_crtc_host_port.sv
// Randomized bench for crtc_host_port: two instances (default and 2/3/2 phase timing)
// compared cycle by cycle against a phase-arithmetic reference model.
module tb_crtc_host_port;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req_valid;
  logic [4:0] req_reg;
  logic       req_read;
  logic [7:0] req_data;
  logic       ar_flush;
  logic [7:0] d_in;

  logic [1:0] req_ready, rd_valid, e_w, csn_w, rs_w, rw_w, doe_w;
  logic [7:0] rd_data_w [2];
  logic [7:0] dout_w [2];

  crtc_host_port #(.SETUP(1), .HIGH(2), .HOLD(1)) u_dut0 (
    .CLK(clk), .RST(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_reg(req_reg), .req_read(req_read), .req_data(req_data), .ar_flush(ar_flush),
    .rd_valid(rd_valid[0]), .rd_data(rd_data_w[0]), .E(e_w[0]), .CSn(csn_w[0]),
    .RS(rs_w[0]), .RW(rw_w[0]), .D_OUT(dout_w[0]), .D_OE(doe_w[0]), .D_IN(d_in));

  crtc_host_port #(.SETUP(2), .HIGH(3), .HOLD(2)) u_dut1 (
    .CLK(clk), .RST(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_reg(req_reg), .req_read(req_read), .req_data(req_data), .ar_flush(ar_flush),
    .rd_valid(rd_valid[1]), .rd_data(rd_data_w[1]), .E(e_w[1]), .CSn(csn_w[1]),
    .RS(rs_w[1]), .RW(rw_w[1]), .D_OUT(dout_w[1]), .D_OE(doe_w[1]), .D_IN(d_in));

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         m_valid [2];
  logic [4:0] m_reg   [2];
  logic [7:0] m_rd    [2];

  function automatic int p_s(int i); return (i == 1) ? 2 : 1; endfunction
  function automatic int p_h(int i); return (i == 1) ? 3 : 2; endfunction
  function automatic int p_o(int i); return (i == 1) ? 2 : 1; endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle(int i);
    check($sformatf("csn_idle%0d", i), csn_w[i], 1);
    check($sformatf("ready_idle%0d", i), req_ready[i], 1);
    check($sformatf("e_idle%0d", i), e_w[i], 0);
    check($sformatf("rw_idle%0d", i), rw_w[i], 1);
    check($sformatf("rs_idle%0d", i), rs_w[i], 0);
    check($sformatf("doe_idle%0d", i), doe_w[i], 0);
    check($sformatf("dout_idle%0d", i), dout_w[i], 0);
    check($sformatf("rd_data%0d", i), rd_data_w[i], m_rd[i]);
  endtask

  task automatic idle_cycle(int i);
    @(negedge clk);
    check_idle(i);
    check($sformatf("rd_valid_quiet%0d", i), rd_valid[i], 0);
  endtask

  // Expected bus pins in cycle k (1-based) of a transfer, from phase arithmetic.
  task automatic check_cycle(int i, int k, bit miss, bit rd, logic [4:0] r, logic [7:0] d);
    int  n  = p_s(i) + p_h(i) + p_o(i);
    int  ph = (k - 1) % n;
    bit  ad = miss && (k <= n);
    check($sformatf("csn%0d_k%0d", i, k), csn_w[i], 0);
    check($sformatf("ready%0d_k%0d", i, k), req_ready[i], 0);
    check($sformatf("e%0d_k%0d", i, k), e_w[i], (ph >= p_s(i)) && (ph < p_s(i) + p_h(i)));
    check($sformatf("rs%0d_k%0d", i, k), rs_w[i], !ad);
    check($sformatf("rw%0d_k%0d", i, k), rw_w[i], ad ? 1'b0 : rd);
    check($sformatf("doe%0d_k%0d", i, k), doe_w[i], ad ? 1'b1 : !rd);
    check($sformatf("dout%0d_k%0d", i, k), dout_w[i], ad ? {3'b000, r} : (rd ? 8'd0 : d));
    check($sformatf("rdv%0d_k%0d", i, k), rd_valid[i], 0);
  endtask

  task automatic accept(int i, logic [4:0] r, bit rd, logic [7:0] d, bit fl_acc);
    check($sformatf("ready_pre%0d", i), req_ready[i], 1);
    req_valid[i] = 1'b1;
    req_reg      = r;
    req_read     = rd;
    req_data     = d;
    ar_flush     = fl_acc;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    ar_flush  = 1'b0;
    req_reg   = 5'($urandom);
    req_read  = 1'($urandom);
    req_data  = 8'($urandom);
  endtask

  task automatic xfer(int i, logic [4:0] r, bit rd, logic [7:0] d, logic [7:0] din,
                      bit fl_acc, int fl_k);
    int n = p_s(i) + p_h(i) + p_o(i);
    bit miss = !m_valid[i] || (m_reg[i] != r) || fl_acc;
    int len = miss ? 2 * n : n;
    int k_sample = (miss ? n : 0) + p_s(i) + p_h(i);
    bit flushed = fl_acc;
    accept(i, r, rd, d, fl_acc);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      check_cycle(i, k, miss, rd, r, d);
      d_in = (k == k_sample) ? din : ~din;
      if (k == fl_k) begin
        ar_flush = 1'b1;
        flushed  = 1'b1;
      end else begin
        ar_flush = 1'b0;
      end
    end
    @(negedge clk);
    ar_flush = 1'b0;
    if (flushed) begin
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
    end else begin
      m_valid[i] = 1'b1;
      m_reg[i]   = r;
    end
    if (rd) m_rd[i] = din;
    check_idle(i);
    check($sformatf("rd_valid_end%0d", i), rd_valid[i], rd);
  endtask

  task automatic xfer_abort(int i, logic [4:0] r, int ab_k);
    int n = p_s(i) + p_h(i) + p_o(i);
    bit miss = !m_valid[i] || (m_reg[i] != r);
    int ph = (ab_k - 1) % n;
    accept(i, r, 1'b0, 8'h5A, 1'b0);
    for (int k = 1; k <= ab_k; k++) @(negedge clk);
    check($sformatf("e_pre_abort%0d", i), e_w[i], (ph >= p_s(i)) && (ph < p_s(i) + p_h(i)));
    check($sformatf("rs_pre_abort%0d", i), rs_w[i], !(miss && ab_k <= n));
    rst = 1'b1;
    #1;
    m_valid[0] = 1'b0;
    m_valid[1] = 1'b0;
    m_rd[0]    = 8'd0;
    m_rd[1]    = 8'd0;
    check_idle(i);
    check($sformatf("rdv_abort%0d", i), rd_valid[i], 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycle(i);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_reg   = 5'd0;
    req_read  = 1'b0;
    req_data  = 8'd0;
    ar_flush  = 1'b0;
    d_in      = 8'd0;
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_reg[i]   = 5'd0;
      m_rd[i]    = 8'd0;
    end
    repeat (2) @(negedge clk);
    check_idle(0);
    check_idle(1);
    check("rdv_reset0", rd_valid[0], 0);
    check("rdv_reset1", rd_valid[1], 0);
    rst = 1'b0;
    idle_cycle(0);

    // Directed sequence on the default-timing instance.
    xfer(0, 5'd1, 1'b0, 8'h50, 8'h00, 1'b0, 0);
    xfer(0, 5'd1, 1'b0, 8'h28, 8'h00, 1'b0, 0);
    xfer(0, 5'd14, 1'b1, 8'h00, 8'h3C, 1'b0, 0);
    idle_cycle(0);
    xfer(0, 5'd14, 1'b0, 8'h77, 8'h00, 1'b0, 0);
    xfer(0, 5'd1, 1'b0, 8'h11, 8'h00, 1'b1, 0);
    xfer(0, 5'd1, 1'b0, 8'h12, 8'h00, 1'b0, 2);
    xfer(0, 5'd1, 1'b0, 8'h13, 8'h00, 1'b0, 0);
    xfer(0, 5'd9, 1'b0, 8'h00, 8'h00, 1'b0, 0);
    xfer_abort(0, 5'd1, 2);
    xfer(0, 5'd1, 1'b0, 8'h14, 8'h00, 1'b0, 0);
    xfer(0, 5'd31, 1'b1, 8'h00, 8'hA5, 1'b0, 0);

    // Stretched-timing instance: miss 14 cycles, hit 7.
    xfer(1, 5'd5, 1'b0, 8'hC3, 8'h00, 1'b0, 0);
    xfer(1, 5'd5, 1'b1, 8'h00, 8'h96, 1'b0, 0);
    idle_cycle(1);
    xfer(1, 5'd5, 1'b0, 8'h01, 8'h00, 1'b0, 4);

    for (int t = 0; t < 60; t++) begin
      int         i    = int'($urandom_range(0, 1));
      logic [4:0] r;
      case ($urandom_range(0, 3))
        0:       r = 5'd0;
        1:       r = 5'd1;
        2:       r = 5'd2;
        default: r = 5'd31;
      endcase
      if ($urandom_range(0, 15) == 0) begin
        xfer_abort(i, r, int'($urandom_range(1, p_s(i) + p_h(i) + p_o(i))));
      end else begin
        xfer(i, r, 1'($urandom), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 10)) : 0);
      end
      repeat ($urandom_range(0, 2)) idle_cycle(i);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crtc_host_port.md
# crtc_host_port

Host-side bus initiator for the MC6845 CRTC processor interface. Converts a simple valid/ready register-access request into the two-step 6845 bus sequence: an address-register write (RS=0), then a data access (RS=1) to the selected register. It generates E, CSn, RS, RW and the data bus with programmable phase lengths. It sits between the system control logic or boot sequencer and the CRTC core, and caches the last address written so repeated accesses to the same register skip the address step.

## Interface
- SETUP, default 1: CLK cycles per bus cycle with CSn/RS/RW/D valid and E low before E rises; legal values ≥1.
- HIGH, default 2: CLK cycles E is high; legal values ≥1.
- HOLD, default 1: CLK cycles E is low after its falling edge with CSn/RS/RW/D still held; legal values ≥1.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- req_valid  in  1  access request present.
- req_ready  out  1  block idle and able to accept a request.
- req_reg  in  5  target register number; sent unfiltered, including values >17.
- req_read  in  1  1 = read the register, 0 = write it.
- req_data  in  8  write data.
- ar_flush  in  1  invalidates the cached address-register contents.
- rd_valid  out  1  one-cycle pulse when a read completes.
- rd_data  out  8  last read value; held until the next read completes.
- E  out  1  6845 enable strobe.
- CSn  out  1  chip select, active low.
- RS  out  1  0 = address register, 1 = selected data register.
- RW  out  1  0 = write, 1 = read.
- D_OUT  out  8  bus write data.
- D_OE  out  1  drive enable for D_OUT.
- D_IN  in  8  bus read data.

## Operation
- States: IDLE, A_SETUP, A_HIGH, A_HOLD, D_SETUP, D_HIGH, D_HOLD.
- A phase counter counts the cycles in each non-IDLE state.
- Accept on a CLK edge where req_valid && req_ready. req_reg, req_read and req_data are captured at that edge.
- Next state after accept:
  - A_SETUP if the cache is invalid, the cached register differs from req_reg, or ar_flush is high on the same edge (flush wins).
  - D_SETUP otherwise.
- Address bus cycle (A_SETUP, A_HIGH, A_HOLD):
  - CSn=0, RS=0, RW=0, D_OE=1.
  - D_OUT = {3'b000, reg}.
  - E=1 only in A_HIGH.
  - On leaving A_HOLD: cache valid=1, cached register=reg.
- Data bus cycle (D_SETUP, D_HIGH, D_HOLD):
  - CSn=0, RS=1, RW=req_read.
  - Write: D_OE=1, D_OUT=data.
  - Read: D_OE=0, D_OUT=0. D_IN is sampled into rd_data at the edge that ends the final D_HIGH cycle.
  - E=1 only in D_HIGH.
- CSn stays low continuously from A_SETUP (or D_SETUP) through D_HOLD.
- After D_HOLD the state returns to IDLE. On that same cycle rd_valid=1 for reads only.
- ar_flush in any state clears cache valid. If it is asserted during an address bus cycle, the flush wins and the cache stays invalid after A_HOLD.
- IDLE outputs: E=0, CSn=1, RS=0, RW=1, D_OE=0, D_OUT=0, req_ready=1.
- req_ready=1 only in IDLE.

## Timing
- Let N = SETUP+HIGH+HOLD.
- Cache miss: CSn is low for 2N cycles, starting the cycle after the accept edge. req_ready is high again on the following cycle. The earliest next accept is 2N+1 edges after the previous one.
- Cache hit: CSn is low for N cycles; the earliest next accept is N+1 edges later.
- Defaults: miss = 8 busy cycles, hit = 4 busy cycles.
- E rises exactly SETUP cycles after CSn falls (per bus cycle) and is high for exactly HIGH cycles.
- RS, RW and D_OUT change only in cycles where E=0.
- rd_valid coincides with the first IDLE cycle after D_HOLD. rd_data is stable from that cycle on.
- Reset, at any time including mid-transfer:
  - Asynchronously forces IDLE outputs, rd_valid=0, rd_data=0 and cache valid=0.
  - The in-flight access is abandoned and never resumed.
- Back-to-back requests with req_valid held high are accepted on the first IDLE edge, so the minimum CSn-high gap is 1 cycle.

## Test plan
- Reset, then write reg 1 = 0x50 with defaults → CSn low 8 cycles. Address cycle drives RS=0, D_OUT=0x01 with E high in cycles 2–3. Data cycle drives RS=1, RW=0, D_OUT=0x50 with E high in cycles 6–7. req_ready returns high in cycle 9.
- Write reg 1 = 0x28 immediately after → cache hit, single 4-cycle data cycle, no RS=0 cycle.
- Read reg 14 with D_IN=0x3C during D_HIGH → RW=1 and D_OE=0 in the data cycle. rd_valid pulses once, rd_data=0x3C and holds through a subsequent write.
- Repeat a reg 1 write with ar_flush high on the accept edge, then again with ar_flush pulsed mid-address-cycle → both take the 8-cycle path, and the following reg 1 access is also a miss.
- Assert RST during A_HIGH → E=0 and CSn=1 asynchronously. The next reg 1 write after release takes the full 8-cycle miss path.
- SETUP=2, HIGH=3, HOLD=2 → E high for exactly 3 cycles starting 2 cycles after CSn falls. Miss length 14, hit length 7.
